// File: rtl/traffic_phase_ctrl.sv
// N-phase traffic-light controller: latched requests served round-robin with
// min/max green, yellow and all-red clearance, plus a phase-0 preemption input.
module traffic_phase_ctrl #(
  parameter int NPH = 4,
  parameter int WL  = 10,
  localparam int PW = $clog2(NPH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NPH-1:0]    REQ,
  input  logic              PREEMPT,
  input  logic [WL-1:0]     GREEN_MIN,
  input  logic [WL-1:0]     GREEN_MAX,
  input  logic [WL-1:0]     YEL_TIME,
  input  logic [WL-1:0]     RED_TIME,
  output logic [2*NPH-1:0]  LIGHT,
  output logic [PW-1:0]     PHASE,
  output logic [NPH-1:0]    PENDING
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WL-1:0]      timer_q, timer_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [PW-1:0]      next_q, next_d;
  logic [NPH-1:0]     pending_q, pending_d;
  logic [WL-1:0]      min_q, min_d;
  logic [WL-1:0]      max_q, max_d;
  logic [WL-1:0]      yel_q, yel_d;
  logic [WL-1:0]      red_q, red_d;
  logic               boot_q, boot_d;
  logic [2*NPH-1:0]   light_q, light_d;

  logic [WL:0]        elapsed;
  logic [WL-1:0]      red_dur;
  logic [WL-1:0]      gmax_eff;
  logic               others;
  logic               rr_found;
  logic [PW-1:0]      rr_idx;

  function automatic logic [WL-1:0] nz(input logic [WL-1:0] v);
    return (v == '0) ? WL'(1) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    next_d    = next_q;
    min_d     = min_q;
    max_d     = max_q;
    yel_d     = yel_q;
    red_d     = red_q;
    boot_d    = boot_q;
    light_d   = '0;
    rr_found  = 1'b0;
    rr_idx    = '0;

    elapsed  = {1'b0, timer_q} + (WL+1)'(1);
    others   = |(pending_q & ~(NPH'(1) << phase_q));
    // The clearance that follows reset has no latched duration, so it tracks RED_TIME live.
    red_dur  = boot_q ? nz(RED_TIME) : red_q;
    gmax_eff = nz(GREEN_MAX);

    // Wrap-around search starting just after the current phase.
    for (int unsigned k = 1; k < NPH; k++) begin
      int unsigned idx;
      idx = (32'(phase_q) + k) % 32'(NPH);
      if (!rr_found && pending_q[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PW'(idx);
      end
    end

    case (state_q)
      ST_GREEN: begin
        if ((PREEMPT && phase_q != '0) ||
            (elapsed >= {1'b0, min_q} && others &&
             (!REQ[phase_q] || elapsed >= {1'b0, max_q}))) begin
          state_d = ST_YELLOW;
          next_d  = PREEMPT ? '0 : rr_idx;
          yel_d   = nz(YEL_TIME);
        end
      end
      ST_YELLOW: begin
        if (elapsed >= {1'b0, yel_q}) begin
          state_d = ST_ALLRED;
          red_d   = nz(RED_TIME);
        end
      end
      ST_ALLRED: begin
        if (elapsed >= {1'b0, red_dur}) begin
          state_d = ST_GREEN;
          phase_d = PREEMPT ? '0 : next_q;
          boot_d  = 1'b0;
          min_d   = nz(GREEN_MIN);
          max_d   = (gmax_eff < nz(GREEN_MIN)) ? nz(GREEN_MIN) : gmax_eff;
        end
      end
      default: state_d = ST_ALLRED;
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (&timer_q)      timer_d = timer_q;
    else                    timer_d = timer_q + WL'(1);

    pending_d = pending_q | REQ;
    if (state_q == ST_GREEN) pending_d[phase_q] = 1'b0;
    if (state_d == ST_GREEN) pending_d[phase_d] = 1'b0;

    for (int unsigned i = 0; i < NPH; i++) begin
      if (phase_d == PW'(i)) begin
        if (state_d == ST_GREEN)       light_d[2*i +: 2] = 2'b10;
        else if (state_d == ST_YELLOW) light_d[2*i +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_ALLRED;
      timer_q   <= '0;
      phase_q   <= '0;
      next_q    <= '0;
      pending_q <= '0;
      min_q     <= WL'(1);
      max_q     <= WL'(1);
      yel_q     <= WL'(1);
      red_q     <= WL'(1);
      boot_q    <= 1'b1;
      light_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      next_q    <= next_d;
      pending_q <= pending_d;
      min_q     <= min_d;
      max_q     <= max_d;
      yel_q     <= yel_d;
      red_q     <= red_d;
      boot_q    <= boot_d;
      light_q   <= light_d;
    end
  end

  assign LIGHT   = light_q;
  assign PHASE   = phase_q;
  assign PENDING = pending_q;

endmodule
